// File: rtl/pkt_ctrl_pkg.sv
// Shared definitions for the packet parser / system state manager:
// command codes, FSM state encoding and STATUS reply constants.
package pkt_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_NOP    = 4'd0,
    CMD_MODE   = 4'd1,
    CMD_WRITE  = 4'd2,
    CMD_STATUS = 4'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP,
    ST_RESPOND
  } state_e;

  localparam logic [7:0]  REPLY_MAGIC = 8'hA5;
  localparam int unsigned REPLY_LEN   = 4;

endpackage

// File: rtl/byte_slicer.sv
// Loads one byte and shifts it out MSB-first as 8/FIFO_W words, one per cycle,
// starting the cycle after the load. pending_o counts words still to emit.
module byte_slicer #(
  parameter int unsigned FIFO_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [7:0]        byte_i,
  output logic              valid_o,
  output logic [FIFO_W-1:0] data_o,
  output logic [3:0]        pending_o
);

  localparam int unsigned SLICES = 8 / FIFO_W;

  logic [7:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;

  // A load may coincide with the final slice, giving back-to-back bytes.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      sh_d  = sh_q << FIFO_W;
      cnt_d = cnt_q - 4'd1;
    end
    if (load_i) begin
      sh_d  = byte_i;
      cnt_d = 4'(SLICES);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o   = (cnt_q != '0);
  assign data_o    = sh_q[7 -: FIFO_W];
  assign pending_o = cnt_q;

endmodule

// File: rtl/pkt_ctrl_mgr.sv
// Packet parser and system state manager: decodes RX byte packets, applies mode
// changes, slices WRITE payload into per-channel FIFO words, answers STATUS on TX.
module pkt_ctrl_mgr
  import pkt_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_W   = 4,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned UW       = 11,
  parameter int unsigned HEADROOM = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 rx_last,
  input  logic                 rx_user,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last,
  output logic [FIFO_W-1:0]    fifo_data,
  output logic [NUM_CH-1:0]    fifo_wrreq,
  input  logic [NUM_CH*UW-1:0] fifo_used,
  output logic [3:0]           mode,
  output logic [7:0]           err_count
);

  localparam int unsigned CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDXW    = $clog2(REPLY_LEN);
  localparam int unsigned FULL_TH = (1 << UW) - HEADROOM;

  state_e          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d, wr_ch_q;
  logic [3:0]      mode_q, mode_d;
  logic [7:0]      err_q;
  logic            reply_q, reply_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            err_inc, load, acc, last_idx;
  logic [NUM_CH-1:0] full_vec;
  logic [7:0]      flags8;
  logic            sl_valid;
  logic [3:0]      sl_pend;
  logic [3:0]      cmd, arg;

  always_comb begin
    full_vec = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      full_vec[c] = (fifo_used[c*UW +: UW] >= UW'(FULL_TH));
    end
  end

  assign flags8 = 8'(full_vec);
  assign cmd    = rx_data[7:4];
  assign arg    = rx_data[3:0];

  // Full is only consulted while a new byte could be accepted; a byte already
  // loaded into the slicer always drains.
  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DROP: rx_ready = rst;
      ST_PAYLOAD:       rx_ready = rst & ~full_vec[ch_q] & (sl_pend <= 4'd1);
      default:          rx_ready = 1'b0;
    endcase
  end

  assign acc      = rx_valid & rx_ready;
  assign last_idx = (idx_q == IDXW'(REPLY_LEN - 1));

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    mode_d   = mode_q;
    reply_d  = reply_q;
    idx_d    = idx_q;
    err_inc  = 1'b0;
    load     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (rx_user) begin
            err_inc = 1'b1;
            reply_d = 1'b0;
            state_d = rx_last ? ST_IDLE : ST_DROP;
          end else begin
            state_d = ST_DROP;
            case (cmd)
              CMD_NOP:    ;
              CMD_MODE:   mode_d = arg;
              CMD_WRITE: begin
                if (32'(arg) < NUM_CH) begin
                  ch_d    = CHW'(arg);
                  state_d = ST_PAYLOAD;
                end else begin
                  err_inc = 1'b1;
                end
              end
              CMD_STATUS: reply_d = 1'b1;
              default:    err_inc = 1'b1;
            endcase
            if (rx_last) state_d = reply_d ? ST_RESPOND : ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (acc) begin
          if (rx_user) begin
            err_inc = 1'b1;
            reply_d = 1'b0;
            state_d = rx_last ? ST_IDLE : ST_DROP;
          end else if (rx_last) begin
            state_d = reply_q ? ST_RESPOND : ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          if (rx_user) begin
            err_inc = 1'b1;
            reply_d = 1'b0;
            state_d = rx_last ? ST_IDLE : ST_DROP;
          end else begin
            load = 1'b1;
            if (rx_last) state_d = ST_IDLE;
          end
        end
      end
      ST_RESPOND: begin
        tx_valid = 1'b1;
        tx_last  = last_idx;
        case (idx_q)
          2'd0:    tx_data = REPLY_MAGIC;
          2'd1:    tx_data = {4'h0, mode_q};
          2'd2:    tx_data = err_q;
          default: tx_data = flags8;
        endcase
        if (tx_ready) begin
          if (last_idx) begin
            idx_d   = '0;
            reply_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      wr_ch_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      reply_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      mode_q  <= mode_d;
      reply_q <= reply_d;
      idx_q   <= idx_d;
      // Channel travels with the byte so trailing slices survive a new header.
      if (load) wr_ch_q <= ch_q;
      if (err_inc && err_q != '1) err_q <= err_q + 8'd1;
    end
  end

  byte_slicer #(
    .FIFO_W(FIFO_W)
  ) u_slicer (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (load),
    .byte_i   (rx_data),
    .valid_o  (sl_valid),
    .data_o   (fifo_data),
    .pending_o(sl_pend)
  );

  always_comb begin
    fifo_wrreq = '0;
    if (sl_valid) fifo_wrreq[wr_ch_q] = 1'b1;
  end

  assign mode      = mode_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_pkt_ctrl_mgr.sv
// Directed self-checking bench for pkt_ctrl_mgr at default parameters
// (FIFO_W=4, NUM_CH=2, UW=11, HEADROOM=16).
module tb_pkt_ctrl_mgr;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_last, rx_user;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_last;
  logic [3:0]  fifo_data;
  logic [1:0]  fifo_wrreq;
  logic [21:0] fifo_used;
  logic [3:0]  mode;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] wr_q[$];

  always #4 clk = ~clk;

  pkt_ctrl_mgr #(
    .FIFO_W(4), .NUM_CH(2), .UW(11), .HEADROOM(16)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_last(rx_last), .rx_user(rx_user),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .fifo_used(fifo_used),
    .mode(mode), .err_count(err_count)
  );

  // Record every FIFO write as {2'b0, wrreq, data}.
  always @(negedge clk)
    if (rst && fifo_wrreq != '0) wr_q.push_back({2'b00, fifo_wrreq, fifo_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic user);
    int unsigned n = 0;
    rx_data  = d;
    rx_valid = 1'b1;
    rx_last  = last;
    rx_user  = user;
    while (!rx_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!rx_ready) check("accept_timeout", rx_ready, 1);
    step(1);
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_user  = 1'b0;
  endtask

  task automatic check_words(input string tag, input int unsigned n, input logic [7:0] exp[]);
    check({tag, "_count"}, wr_q.size(), n);
    for (int i = 0; i < int'(n); i++)
      check(tag, (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD, exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_reply[4];
    logic [7:0] w[];
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
    tx_ready = 1'b0; fifo_used = '0;

    // 1: reset values, then SET_MODE 7
    step(2);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_wrreq", fifo_wrreq, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_mode", mode, 0);
    check("rst_err", err_count, 0);
    rst = 1'b1;
    step(1);
    send(8'h17, 1'b1, 1'b0);
    check("t1_mode", mode, 7);
    check("t1_err", err_count, 0);
    check("t1_idle_ready", rx_ready, 1);
    check("t1_no_writes", wr_q.size(), 0);

    // 2: WRITE ch1 AB CD -> A,B,C,D on wrreq[1]
    wr_q.delete();
    send(8'h21, 1'b0, 1'b0);
    send(8'hAB, 1'b0, 1'b0);
    check("t2_ready_low", rx_ready, 0);
    check("t2_first_wrreq", fifo_wrreq, 2'b10);
    check("t2_first_data", fifo_data, 4'hA);
    send(8'hCD, 1'b1, 1'b0);
    step(3);
    w = new[4];
    w[0] = 8'h2A; w[1] = 8'h2B; w[2] = 8'h2C; w[3] = 8'h2D;
    check_words("t2_word", 4, w);
    check("t2_idle_ready", rx_ready, 1);
    check("t2_idle_wrreq", fifo_wrreq, 0);

    // 3: ch0 goes full mid-packet, then drops by one
    wr_q.delete();
    send(8'h20, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    fifo_used[10:0] = 11'd2032;
    rx_data = 8'h34; rx_valid = 1'b1;
    step(4);
    check("t3_full_ready", rx_ready, 0);
    check("t3_drained", wr_q.size(), 2);
    fifo_used[10:0] = 11'd2031;
    #1;
    check("t3_resume_ready", rx_ready, 1);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b1, 1'b0);
    step(3);
    w = new[6];
    for (int i = 0; i < 6; i++) w[i] = 8'h11 + 8'(i);
    check_words("t3_word", 6, w);

    // 4: STATUS reply with tx_ready toggling; ch1 reported full
    fifo_used = {11'd2047, 11'd0};
    exp_reply[0] = 8'hA5; exp_reply[1] = 8'h07; exp_reply[2] = 8'h00; exp_reply[3] = 8'h02;
    tx_ready = 1'b0;
    send(8'h30, 1'b1, 1'b0);
    check("t4_respond_rx_ready", rx_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_valid", tx_valid, 1);
      check("t4_data", tx_data, exp_reply[i]);
      check("t4_last", tx_last, (i == 3) ? 1 : 0);
      step(1);
      check("t4_hold", tx_data, exp_reply[i]);
      tx_ready = 1'b1;
      step(1);
      tx_ready = 1'b0;
    end
    check("t4_done_valid", tx_valid, 0);
    check("t4_done_ready", rx_ready, 1);
    fifo_used = '0;

    // 5: bad channel, rx_user, reply cancel, saturation
    wr_q.delete();
    send(8'h2F, 1'b0, 1'b0);
    send(8'h99, 1'b1, 1'b0);
    check("t5_err1", err_count, 1);
    check("t5_no_payload", wr_q.size(), 0);
    send(8'h1A, 1'b1, 1'b1);
    check("t5_user_err", err_count, 2);
    check("t5_user_mode", mode, 7);
    send(8'h30, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b1);
    check("t5_cancel_err", err_count, 3);
    check("t5_cancel_tx", tx_valid, 0);
    check("t5_cancel_ready", rx_ready, 1);
    for (int i = 0; i < 255; i++) send(8'hF0, 1'b1, 1'b0);
    check("t5_saturate", err_count, 8'hFF);

    // 6: reset mid-PAYLOAD and mid-RESPOND
    send(8'h21, 1'b0, 1'b0);
    send(8'hAB, 1'b0, 1'b0);
    check("t6_pre_wrreq", fifo_wrreq, 2'b10);
    rst = 1'b0;
    #1;
    check("t6_pl_wrreq", fifo_wrreq, 0);
    check("t6_pl_data", fifo_data, 0);
    check("t6_pl_ready", rx_ready, 0);
    check("t6_pl_mode", mode, 0);
    check("t6_pl_err", err_count, 0);
    #2 rst = 1'b1;
    step(1);
    send(8'h30, 1'b1, 1'b0);
    check("t6_pre_tx", tx_valid, 1);
    rst = 1'b0;
    #1;
    check("t6_rs_tx_valid", tx_valid, 0);
    check("t6_rs_tx_data", tx_data, 0);
    check("t6_rs_tx_last", tx_last, 0);
    #2 rst = 1'b1;
    step(1);
    wr_q.delete();
    send(8'h13, 1'b1, 1'b0);
    check("t6_mode", mode, 3);
    send(8'h21, 1'b0, 1'b0);
    send(8'h5E, 1'b1, 1'b0);
    step(3);
    w = new[2];
    w[0] = 8'h25; w[1] = 8'h2E;
    check_words("t6_word", 2, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
